// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: PC counter handshake, instruction-memory read port and
// the consumer-side instruction stream.
interface inst_fetch_queue_if #(
    parameter int INST_ADDR_WIDTH = 6,
    parameter int INST_WIDTH      = 32
);
    logic [INST_ADDR_WIDTH-1:0] pc_in;
    logic                       pc_adv;
    logic                       imem_ren;
    logic [INST_ADDR_WIDTH-1:0] imem_addr;
    logic [INST_WIDTH-1:0]      imem_rdata;
    logic                       flush;
    logic                       inst_valid;
    logic                       inst_ready;
    logic [INST_WIDTH-1:0]      inst_data;
    logic [INST_ADDR_WIDTH-1:0] inst_pc;

    modport slave (
        input  pc_in, imem_rdata, flush, inst_ready,
        output pc_adv, imem_ren, imem_addr, inst_valid, inst_data, inst_pc
    );

    modport master (
        output pc_in, imem_rdata, flush, inst_ready,
        input  pc_adv, imem_ren, imem_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: issues one-cycle-latency memory reads while
// space remains (counting the in-flight read) and buffers tagged words.
module inst_fetch_queue #(
    parameter int INST_ADDR_WIDTH = 6,
    parameter int INST_WIDTH      = 32,
    parameter int DEPTH           = 4
) (
    input  logic                clk,
    input  logic                reset,
    inst_fetch_queue_if.slave   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    logic [CW-1:0]              r_count;
    logic [PW-1:0]              r_wptr;
    logic [PW-1:0]              r_rptr;
    logic                       r_inflight;
    logic [INST_ADDR_WIDTH-1:0] r_inflight_pc;
    logic [INST_WIDTH-1:0]      r_mem_data [DEPTH];
    logic [INST_ADDR_WIDTH-1:0] r_mem_pc   [DEPTH];

    logic          w_valid;
    logic          w_pop;
    logic          w_wr;
    logic          w_ren;
    logic [OW-1:0] w_occ;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & bus.inst_ready;
    assign w_wr    = r_inflight & ~bus.flush;
    // Occupancy after this cycle's pop, including the read already in flight
    assign w_occ   = OW'(r_count) + OW'(r_inflight) - OW'(w_pop);
    // Gating by reset keeps the strobe low while the async reset is held
    assign w_ren   = reset & ~bus.flush & (w_occ < OW'(DEPTH));

    assign bus.imem_ren   = w_ren;
    assign bus.pc_adv     = w_ren;
    assign bus.imem_addr  = bus.pc_in;
    assign bus.inst_valid = w_valid;
    assign bus.inst_data  = r_mem_data[r_rptr];
    assign bus.inst_pc    = r_mem_pc[r_rptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_inflight <= 1'b0;
        end else if (bus.flush) begin
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_ren;
            if (w_wr)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        r_inflight_pc <= bus.pc_in;
        if (w_wr) begin
            r_mem_data[r_wptr] <= bus.imem_rdata;
            r_mem_pc[r_wptr]   <= r_inflight_pc;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a tracker queues expected words as
// reads issue, a monitor pops and compares on every accepted instruction.
module tb_inst_fetch_queue;
    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } item_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [AW-1:0] pc;

    always #5 clk = ~clk;

    inst_fetch_queue_if #(.INST_ADDR_WIDTH(AW), .INST_WIDTH(DW)) bus ();

    inst_fetch_queue #(
        .INST_ADDR_WIDTH(AW),
        .INST_WIDTH(DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // PC counter and one-cycle instruction memory
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= '0;
        else if (bus.pc_adv) pc <= pc + AW'(1);
    end
    assign bus.pc_in = pc;

    always_ff @(posedge clk) begin
        if (bus.imem_ren) bus.imem_rdata <= 32'hA000_0000 + DW'(bus.imem_addr);
        else              bus.imem_rdata <= 32'hBAD0_0000;
    end

    item_t sb[$];
    int tests = 0;
    int fails = 0;
    int n_pops = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Tracker: expected words enter the scoreboard when a read is issued
    initial begin
        logic s_rst, s_fl, s_ren, s_adv;
        logic [AW-1:0] s_addr, s_pc;
        item_t it;
        forever begin
            @(negedge clk);
            s_rst  = reset;
            s_fl   = bus.flush;
            s_ren  = bus.imem_ren;
            s_adv  = bus.pc_adv;
            s_addr = bus.imem_addr;
            s_pc   = pc;
            #1;
            chk("pc_adv_eq_ren", 64'(s_adv), 64'(s_ren));
            chk("addr_eq_pc", 64'(s_addr), 64'(s_pc));
            if (!s_rst) begin
                chk("ren_in_reset", 64'(s_ren), 64'(0));
                sb.delete();
            end else if (s_fl) begin
                chk("ren_in_flush", 64'(s_ren), 64'(0));
                sb.delete();
            end else begin
                chk("ren_capacity", 64'(s_ren), 64'(sb.size() < DEPTH));
                if (s_ren) begin
                    it.pc   = s_addr;
                    it.data = 32'hA000_0000 + DW'(s_addr);
                    sb.push_back(it);
                end
            end
        end
    end

    // Monitor: compare every accepted head against the scoreboard
    initial begin
        item_t e;
        logic have_prev = 1'b0;
        logic [DW-1:0] prev_d;
        logic [AW-1:0] prev_pc;
        forever begin
            @(negedge clk);
            if (reset && !bus.flush) begin
                if (have_prev) begin
                    chk("hold_valid", 64'(bus.inst_valid), 64'(1));
                    chk("hold_data", 64'(bus.inst_data), 64'(prev_d));
                    chk("hold_pc", 64'(bus.inst_pc), 64'(prev_pc));
                end
                if (bus.inst_valid && bus.inst_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL underflow: got pop of pc %0h expected empty queue", bus.inst_pc);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_inst_pc", 64'(bus.inst_pc), 64'(e.pc));
                        chk("sb_inst_data", 64'(bus.inst_data), 64'(e.data));
                        n_pops++;
                    end
                end
            end
            have_prev = reset && !bus.flush && bus.inst_valid && !bus.inst_ready;
            prev_d    = bus.inst_data;
            prev_pc   = bus.inst_pc;
        end
    end

    task automatic restart(input logic rdy);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.flush = 1'b0;
        bus.inst_ready = rdy;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        int n;
        int p0;
        bus.flush = 1'b0;
        bus.inst_ready = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(bus.inst_valid), 64'(0));
        chk("rst_ren", 64'(bus.imem_ren), 64'(0));
        chk("rst_adv", 64'(bus.pc_adv), 64'(0));

        // Streaming from reset release with the consumer always ready
        @(posedge clk); #1;
        bus.inst_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("A_c0_ren", 64'(bus.imem_ren), 64'(1));
        chk("A_c0_valid", 64'(bus.inst_valid), 64'(0));
        @(negedge clk);
        chk("A_c1_valid", 64'(bus.inst_valid), 64'(0));
        @(negedge clk);
        chk("A_c2_valid", 64'(bus.inst_valid), 64'(1));
        chk("A_c2_pc", 64'(bus.inst_pc), 64'(0));
        chk("A_c2_data", 64'(bus.inst_data), 64'(32'hA000_0000));
        #1 p0 = n_pops;
        repeat (10) @(negedge clk);
        #1 chk("A_rate", 64'(n_pops - p0), 64'(10));

        // Fill with consumer stalled, then drain
        restart(1'b0);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            n += int'(bus.imem_ren);
        end
        chk("B_reads", 64'(n), 64'(4));
        chk("B_ren_off", 64'(bus.imem_ren), 64'(0));
        chk("B_valid", 64'(bus.inst_valid), 64'(1));
        chk("B_head_pc", 64'(bus.inst_pc), 64'(0));
        @(posedge clk); #1;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        chk("B_resume_ren", 64'(bus.imem_ren), 64'(1));
        repeat (6) @(negedge clk);

        // Flush with three queued and one in flight
        restart(1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("C_full_ren", 64'(bus.imem_ren), 64'(0));
        chk("C_pre_valid", 64'(bus.inst_valid), 64'(1));
        bus.flush = 1'b1;
        @(negedge clk);
        chk("C_flush_ren", 64'(bus.imem_ren), 64'(0));
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("C_post_valid", 64'(bus.inst_valid), 64'(0));
        @(negedge clk);
        chk("C_c5_valid", 64'(bus.inst_valid), 64'(0));
        chk("C_c5_ren", 64'(bus.imem_ren), 64'(1));
        @(negedge clk);
        chk("C_c6_valid", 64'(bus.inst_valid), 64'(0));
        @(negedge clk);
        chk("C_c7_valid", 64'(bus.inst_valid), 64'(1));
        chk("C_first_pc", 64'(bus.inst_pc), 64'(4));
        @(posedge clk); #1;
        bus.inst_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Asynchronous reset between edges with two queued
        restart(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("D_pre_valid", 64'(bus.inst_valid), 64'(1));
        #1 reset = 1'b0;
        #1;
        chk("D_async_valid", 64'(bus.inst_valid), 64'(0));
        chk("D_async_ren", 64'(bus.imem_ren), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("D_c0_valid", 64'(bus.inst_valid), 64'(0));
        @(negedge clk);
        chk("D_c1_valid", 64'(bus.inst_valid), 64'(0));
        @(negedge clk);
        chk("D_c2_valid", 64'(bus.inst_valid), 64'(1));
        chk("D_c2_pc", 64'(bus.inst_pc), 64'(0));

        // Random consumer backpressure and flushes
        #1 p0 = n_pops;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            bus.inst_ready = ($urandom_range(0, 9) < 6);
            bus.flush = ($urandom_range(0, 11) == 0);
        end
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.inst_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1 chk("E_some_pops", 64'(n_pops - p0 > 40), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter INST_ADDR_WIDTH, default 6, instruction word-address width matching the PC counter output.
REQ-002 SHALL have parameter INST_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; legal values are powers of two, 2..16.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-007 SHALL have port pc_in, input, INST_ADDR_WIDTH, current fetch word address from the PC counter.
REQ-008 SHALL have port pc_adv, output, 1, advance request to the PC counter (drives its en); equals imem_ren.
REQ-009 SHALL have port imem_ren, output, 1, instruction-memory read strobe.
REQ-010 SHALL have port imem_addr, output, INST_ADDR_WIDTH, read address; equals pc_in combinationally.
REQ-011 SHALL have port imem_rdata, input, INST_WIDTH, read data, valid exactly one cycle after imem_ren.
REQ-012 SHALL have port flush, input, 1, redirect: discard all queued and in-flight instructions.
REQ-013 SHALL have port inst_valid, output, 1, queue head valid.
REQ-014 SHALL have port inst_ready, input, 1, consumer accepts head.
REQ-015 SHALL have port inst_data, output, INST_WIDTH, head instruction.
REQ-016 SHALL have port inst_pc, output, INST_ADDR_WIDTH, word address of the head instruction.

Function
REQ-017 SHALL keep count (0..DEPTH), 1-bit inflight, inflight_pc, and circular read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-018 SHALL define pop = inst_valid & inst_ready, and inst_valid = (count != 0).
REQ-019 SHALL assert imem_ren when flush == 0 and count + inflight - pop < DEPTH; pc_adv is identical.
REQ-020 SHALL set inflight to imem_ren and inflight_pc to pc_in on each edge.
REQ-021 SHALL, when inflight == 1 and flush == 0, write imem_rdata with tag inflight_pc at the write pointer and advance it.
REQ-022 SHALL give latency: imem_ren in cycle N -> data written at end of N+1 -> inst_valid earliest in N+2; no combinational bypass.
REQ-023 SHALL, on pop, advance the read pointer; inst_data/inst_pc are read from the head entry.
REQ-024 SHALL, on simultaneous write and pop, leave count unchanged; write into a full queue is impossible by REQ-019.
REQ-025 SHALL sustain one instruction per cycle when inst_ready is held at 1.
REQ-026 SHALL, when flush == 1, at the edge clear count and pointers to 0 and inflight to 0, write nothing, and drop the response of any read issued in the flush cycle's predecessor.
REQ-027 SHALL hold imem_ren low in the flush cycle; fetch resumes the next cycle from the then-current pc_in.
REQ-028 SHALL ignore inst_ready while count == 0; flush with pop in the same cycle acts as flush only.
REQ-029 SHALL hold inst_data/inst_pc stable while inst_valid == 1 and inst_ready == 0.

Reset
REQ-030 SHALL, while reset == 0, immediately force count = 0, pointers = 0, inflight = 0, hence inst_valid = 0, imem_ren = 0, pc_adv = 0, independent of clk.
REQ-031 SHALL, on reset deassertion mid-operation, discard all prior contents; a pending memory response is not written.
REQ-032 SHALL leave storage array contents unreset; inst_data/inst_pc are don't-care while inst_valid == 0.

Verification
REQ-033 SHALL verify: reset release, pc_in 0,1,2,..., memory returns 0xA000_0000 + addr, inst_ready = 1 -> imem_ren from cycle 0, inst_valid from cycle 2, inst_pc 0,1,2,... one per cycle.
REQ-034 SHALL verify: inst_ready = 0 with DEPTH = 4 -> exactly 4 reads issued, count = 4, imem_ren = 0 afterward; then inst_ready = 1 -> 4 pops in order, with fetch resuming in the first pop cycle.
REQ-035 SHALL verify: flush while count = 3 and inflight = 1 -> next cycle inst_valid = 0, the late response is not queued, and the first new inst_pc equals pc_in at resume.
REQ-036 SHALL verify: reset asserted between clock edges with count = 2 -> inst_valid drops to 0 before the next edge.
REQ-037 SHALL verify: 200 cycles of random inst_ready and flush -> output sequence matches a reference queue model, no overflow or underflow, and pointer wrap is exercised.
